// File: rtl/i2s_frame_gen_pkg.sv
// Shared I2S defines: default word width and clock divide used by the
// frame generator and the serializer.
package i2s_frame_gen_pkg;

  localparam int AUDIO_DW_DEFAULT = 8;
  localparam int SCK_DIV_DEFAULT  = 4;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_frame_gen_sample_fifo2.sv
// Two-entry synchronous FIFO holding {left, right} sample pairs;
// simultaneous push and pop are both honoured.
module sample_fifo2 #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full_o  = (count == 2'd2);
  assign empty_o = (count == 2'd0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; the count guarantees
  // no entry is read before it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/i2s_frame_gen.sv
// I2S master bit-clock / word-select generator with a 2-deep stereo sample
// buffer; the data pair is latched once per frame on the ws 1->0 edge.
module i2s_frame_gen
  import i2s_frame_gen_pkg::*;
#(
  parameter int AUDIO_DW = AUDIO_DW_DEFAULT,
  parameter int SCK_DIV  = SCK_DIV_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                sample_valid_i,
  input  logic [AUDIO_DW-1:0] l_sample_i,
  input  logic [AUDIO_DW-1:0] r_sample_i,
  output logic                sample_ready_o,
  output logic                sck_o,
  output logic                ws_o,
  output logic [AUDIO_DW-1:0] l_data_o,
  output logic [AUDIO_DW-1:0] r_data_o,
  output logic                frame_o,
  output logic                underrun_o
);

  localparam int DIV_W = cnt_width(SCK_DIV);
  localparam int BIT_W = cnt_width(AUDIO_DW);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(AUDIO_DW - 1);

  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  div_wrap;
  logic                  sck_fall;
  logic                  bit_wrap;
  logic                  frame_start;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [2*AUDIO_DW-1:0] fifo_head;

  // Each event is a refinement of the previous one, so ws can only move
  // on the same clk edge as a falling sck.
  assign div_wrap    = en_i && (div_cnt == DIV_LAST);
  assign sck_fall    = div_wrap && sck_o;
  assign bit_wrap    = sck_fall && (bit_cnt == BIT_LAST);
  assign frame_start = bit_wrap && ws_o;

  assign sample_ready_o = !fifo_full;
  assign fifo_push      = sample_valid_i && sample_ready_o;
  assign fifo_pop       = frame_start && !fifo_empty;

  sample_fifo2 #(
    .W (2 * AUDIO_DW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({l_sample_i, r_sample_i}),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // NOTE: all state updates use non-blocking assignments so every branch
  // sees the pre-edge values of sck_o, ws_o and the counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      sck_o      <= 1'b0;
      ws_o       <= 1'b1;
      l_data_o   <= '0;
      r_data_o   <= '0;
      frame_o    <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      if (en_i) div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) sck_o <= ~sck_o;
      if (sck_fall) bit_cnt <= bit_wrap ? '0 : bit_cnt + 1'b1;
      if (bit_wrap) ws_o <= ~ws_o;
      frame_o    <= frame_start;
      underrun_o <= frame_start && fifo_empty;
      if (frame_start) begin
        l_data_o <= fifo_empty ? '0 : fifo_head[2*AUDIO_DW-1:AUDIO_DW];
        r_data_o <= fifo_empty ? '0 : fifo_head[AUDIO_DW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_gen.sv
// Self-checking bench for i2s_frame_gen: a time-based reference model derives
// sck/ws from the count of enabled edges and tracks the sample queue.
module tb_i2s_frame_gen;

  localparam int DW    = 8;
  localparam int DIV   = 4;
  localparam int HALF  = 2 * DIV * DW;
  localparam int FRAME = 2 * HALF;
  localparam int VW    = 2 * DW + 5;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          en_i;
  logic          sample_valid_i;
  logic [DW-1:0] l_sample_i;
  logic [DW-1:0] r_sample_i;
  logic          sample_ready_o;
  logic          sck_o;
  logic          ws_o;
  logic [DW-1:0] l_data_o;
  logic [DW-1:0] r_data_o;
  logic          frame_o;
  logic          underrun_o;

  always #5 clk = ~clk;

  i2s_frame_gen #(
    .AUDIO_DW (DW),
    .SCK_DIV  (DIV)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .en_i           (en_i),
    .sample_valid_i (sample_valid_i),
    .l_sample_i     (l_sample_i),
    .r_sample_i     (r_sample_i),
    .sample_ready_o (sample_ready_o),
    .sck_o          (sck_o),
    .ws_o           (ws_o),
    .l_data_o       (l_data_o),
    .r_data_o       (r_data_o),
    .frame_o        (frame_o),
    .underrun_o     (underrun_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int              en_edges;
  logic [2*DW-1:0] q[$];
  logic [DW-1:0]   m_l, m_r;
  logic            m_frame, m_underrun;
  logic            last_accept;

  function automatic logic [VW-1:0] model_vec();
    logic sck, ws, rdy;
    sck = ((en_edges / DIV) % 2) == 1;
    ws  = ((en_edges / HALF) % 2) == 0;
    rdy = q.size() < 2;
    return {sck, ws, m_frame, m_underrun, rdy, m_l, m_r};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {sck_o, ws_o, frame_o, underrun_o, sample_ready_o, l_data_o, r_data_o};
  endfunction

  // Advance one clock, update the model with the inputs the DUT sampled,
  // and return #1 after the edge with outputs settled.
  task automatic tick();
    logic acc, fs;
    @(posedge clk);
    if (rst_i) begin
      en_edges = 0;
      q.delete();
      m_l = '0; m_r = '0; m_frame = 1'b0; m_underrun = 1'b0;
      last_accept = 1'b0;
    end else begin
      acc = sample_valid_i && (q.size() < 2);
      fs  = en_i && (((en_edges + 1) % FRAME) == HALF);
      m_frame    = fs;
      m_underrun = fs && (q.size() == 0);
      if (fs) begin
        if (q.size() > 0) {m_l, m_r} = q.pop_front();
        else begin m_l = '0; m_r = '0; end
      end
      if (acc) q.push_back({l_sample_i, r_sample_i});
      if (en_i) en_edges++;
      last_accept = acc;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; en_i = 1'b0; sample_valid_i = 1'b0;
    l_sample_i = '0; r_sample_i = '0;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; en_i = 1'b1; sample_valid_i = 1'b1;
    l_sample_i = 8'h11; r_sample_i = 8'h22;
    tick();
    tick();
    n_checks++;
    if ({sck_o, ws_o, frame_o, underrun_o, sample_ready_o, l_data_o, r_data_o} !== {5'b01001, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", dut_vec(), {5'b01001, 16'h0000});
    end
    rst_i = 1'b0; en_i = 1'b0; sample_valid_i = 1'b0;
  endtask

  task automatic test_first_frame();
    do_reset();
    en_i = 1'b1;
    for (int e = 1; e <= FRAME; e++) begin
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL first_frame edge %0d: got %h expected %h", e, dut_vec(), model_vec());
      end
      if (e == DIV || e == 2 * DIV) begin
        n_checks++;
        if (sck_o !== (e == DIV)) begin
          n_fail++;
          $display("FAIL first_sck_edge %0d: got %b expected %b", e, sck_o, (e == DIV));
        end
      end
      if (e == HALF) begin
        n_checks++;
        if ({ws_o, frame_o, underrun_o, l_data_o, r_data_o} !== {3'b011, 16'h0000}) begin
          n_fail++;
          $display("FAIL first_frame_start: got %b%b%b %h %h expected ws=0 frame=1 underrun=1 data 0",
                   ws_o, frame_o, underrun_o, l_data_o, r_data_o);
        end
      end
      if (e == FRAME) begin
        n_checks++;
        if (ws_o !== 1'b1) begin
          n_fail++;
          $display("FAIL ws_rise_128: got %b expected 1", ws_o);
        end
      end
    end
  endtask

  task automatic test_single_push();
    do_reset();
    en_i = 1'b1;
    l_sample_i = 8'hA5; r_sample_i = 8'h3C;
    for (int e = 1; e <= FRAME + HALF + 4; e++) begin
      sample_valid_i = (e == 10);
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL single_push edge %0d: got %h expected %h", e, dut_vec(), model_vec());
      end
      if (e >= HALF && e < HALF + FRAME) begin
        n_checks++;
        if ({l_data_o, r_data_o, underrun_o} !== {16'hA53C, 1'b0}) begin
          n_fail++;
          $display("FAIL single_push_hold edge %0d: got %h %h ur=%b expected a5 3c ur=0",
                   e, l_data_o, r_data_o, underrun_o);
        end
      end
    end
    sample_valid_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2*DW-1:0] p [3];
    int acc_edge [3];
    int idx = 0;
    do_reset();
    en_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      p[k] = {DW'($urandom_range(1, 255)), DW'($urandom_range(1, 255))};
      acc_edge[k] = -1;
    end
    for (int e = 1; e <= 2 * FRAME + HALF + 4; e++) begin
      sample_valid_i = (idx < 3);
      if (idx < 3) {l_sample_i, r_sample_i} = p[idx];
      tick();
      if (last_accept && idx < 3) begin
        acc_edge[idx] = e;
        idx++;
      end
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL back_to_back edge %0d: got %h expected %h", e, dut_vec(), model_vec());
      end
      if (e == 2) begin
        n_checks++;
        if (sample_ready_o !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_ready_full: got %b expected 0", sample_ready_o);
        end
      end
      if (e == HALF || e == HALF + FRAME || e == HALF + 2 * FRAME) begin
        n_checks++;
        if ({l_data_o, r_data_o} !== p[(e - HALF) / FRAME]) begin
          n_fail++;
          $display("FAIL b2b_order edge %0d: got %h expected %h", e, {l_data_o, r_data_o},
                   p[(e - HALF) / FRAME]);
        end
      end
    end
    sample_valid_i = 1'b0;
    n_checks++;
    if (acc_edge[0] != 1 || acc_edge[1] != 2 || acc_edge[2] != HALF + 1) begin
      n_fail++;
      $display("FAIL b2b_accept_edges: got %0d %0d %0d expected 1 2 %0d",
               acc_edge[0], acc_edge[1], acc_edge[2], HALF + 1);
    end
  endtask

  task automatic test_push_at_frame_start();
    logic [2*DW-1:0] pair;
    pair = {DW'($urandom_range(1, 255)), DW'($urandom_range(1, 255))};
    do_reset();
    en_i = 1'b1;
    {l_sample_i, r_sample_i} = pair;
    for (int e = 1; e <= FRAME + HALF + 2; e++) begin
      sample_valid_i = (e == HALF);
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL push_at_fs edge %0d: got %h expected %h", e, dut_vec(), model_vec());
      end
      if (e == HALF) begin
        n_checks++;
        if ({underrun_o, l_data_o, r_data_o} !== {1'b1, 16'h0000}) begin
          n_fail++;
          $display("FAIL push_at_fs_underrun: got ur=%b %h %h expected ur=1 00 00",
                   underrun_o, l_data_o, r_data_o);
        end
      end
      if (e == HALF + FRAME) begin
        n_checks++;
        if ({underrun_o, l_data_o, r_data_o} !== {1'b0, pair}) begin
          n_fail++;
          $display("FAIL push_at_fs_next: got ur=%b %h expected ur=0 %h",
                   underrun_o, {l_data_o, r_data_o}, pair);
        end
      end
    end
    sample_valid_i = 1'b0;
  endtask

  task automatic test_enable_pause();
    logic sck_hold, ws_hold;
    logic [2*DW-1:0] pair;
    pair = {DW'($urandom_range(1, 255)), DW'($urandom_range(1, 255))};
    do_reset();
    {l_sample_i, r_sample_i} = pair;
    sck_hold = 1'b0; ws_hold = 1'b0;
    for (int c = 1; c <= HALF + 20; c++) begin
      en_i = !(c >= 21 && c <= 30);
      sample_valid_i = (c == 25);
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL pause cycle %0d: got %h expected %h", c, dut_vec(), model_vec());
      end
      if (c == 20) begin sck_hold = sck_o; ws_hold = ws_o; end
      if (c > 20 && c <= 30) begin
        n_checks++;
        if ({sck_o, ws_o} !== {sck_hold, ws_hold}) begin
          n_fail++;
          $display("FAIL pause_frozen cycle %0d: got %b%b expected %b%b", c, sck_o, ws_o, sck_hold, ws_hold);
        end
      end
      if (c == HALF || c == HALF + 10) begin
        n_checks++;
        if ({frame_o, l_data_o, r_data_o} !== {(c == HALF + 10), (c == HALF) ? 16'h0000 : pair}) begin
          n_fail++;
          $display("FAIL pause_frame_shift cycle %0d: got frame=%b %h", c, frame_o, {l_data_o, r_data_o});
        end
      end
    end
    sample_valid_i = 1'b0;
    en_i = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    en_i = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      sample_valid_i = (c == 2 || c == 66 || c == 67);
      l_sample_i = DW'($urandom_range(1, 255));
      r_sample_i = DW'($urandom_range(1, 255));
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL pre_reset cycle %0d: got %h expected %h", c, dut_vec(), model_vec());
      end
    end
    sample_valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    n_checks++;
    if ({sck_o, ws_o, sample_ready_o, l_data_o, r_data_o} !== {3'b011, 16'h0000}) begin
      n_fail++;
      $display("FAIL mid_reset: got sck=%b ws=%b rdy=%b %h expected 0 1 1 0000",
               sck_o, ws_o, sample_ready_o, {l_data_o, r_data_o});
    end
    rst_i = 1'b0;
    for (int e = 1; e <= FRAME + HALF + 2; e++) begin
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL post_reset edge %0d: got %h expected %h", e, dut_vec(), model_vec());
      end
      if (e == HALF || e == HALF + FRAME) begin
        n_checks++;
        if ({underrun_o, l_data_o, r_data_o} !== {1'b1, 16'h0000}) begin
          n_fail++;
          $display("FAIL flushed_pairs edge %0d: got ur=%b %h", e, underrun_o, {l_data_o, r_data_o});
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 1; c <= 3000; c++) begin
      en_i           = ($urandom_range(0, 7) != 0);
      sample_valid_i = ($urandom_range(0, 3) == 0);
      l_sample_i     = DW'($urandom_range(0, 255));
      r_sample_i     = DW'($urandom_range(0, 255));
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h expected %h", c, dut_vec(), model_vec());
      end
    end
    sample_valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b0; sample_valid_i = 1'b0;
    l_sample_i = '0; r_sample_i = '0;
    en_edges = 0; m_l = '0; m_r = '0; m_frame = 1'b0; m_underrun = 1'b0;
    last_accept = 1'b0;
    test_reset();
    test_first_frame();
    test_single_push();
    test_back_to_back();
    test_push_at_frame_start();
    test_enable_pause();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
